data_mem_responder: RTL

- Memory-side responder for the multicycle core's load/store traffic.
- Accepts one doubleword (64-bit, ld/sd) request from the control/datapath side.
- Performs the access byte-serially over an internal byte-wide RAM, then returns a single-cycle completion pulse with the load data.
- Sits between the datapath address register (AOut) / regB and the register-file write-back path.

---
 rtl/mem_resp_pkg.sv | 17 +
 rtl/byte_ram.sv | 22 ++
 rtl/data_mem_responder.sv | 128 ++++++++++++
 3 files changed

// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the doubleword load/store responder.
package mem_resp_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   localparam int LANES      = 8;
   localparam int ALIGN_BITS = 3;

   function automatic logic is_aligned(input logic [63:0] addr);
      return addr[ALIGN_BITS-1:0] == '0;
   endfunction

endpackage

// File: rtl/byte_ram.sv
// Byte-wide single-port RAM: synchronous write, asynchronous read, no reset.
module byte_ram #(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [7:0]        wdata,
   output logic [7:0]        rdata
);

   logic [7:0] mem [2**ADDR_W];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/data_mem_responder.sv
// Serves one 64-bit ld/sd at a time, byte-serially over a byte RAM,
// and returns a one-cycle completion pulse carrying the load data.
module data_mem_responder
   import mem_resp_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   input  logic              req_write,
   input  logic [DATA_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              req_ready,
   output logic              rsp_valid,
   output logic              rsp_err,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic [1:0]        state_out
);

   state_t            state_reg;
   state_t            state_next;
   logic [ADDR_W-1:0] addr_reg;
   logic              write_reg;
   logic              err_reg;
   logic [DATA_W-1:0] wdata_reg;
   logic [DATA_W-1:0] ldata_reg;
   logic [DATA_W-1:0] rdata_reg;
   logic [2:0]        cnt_reg;

   logic [ADDR_W-1:0] ram_addr;
   logic              ram_we;
   logic [7:0]        ram_wdata;
   logic [7:0]        ram_rdata;
   logic              last_byte;
   logic              unused_addr_bits;

   assign unused_addr_bits = ^req_addr[DATA_W-1:ADDR_W];

   // Byte index wraps naturally in the ADDR_W-bit adder.
   assign ram_addr  = addr_reg + ADDR_W'(cnt_reg);
   assign ram_we    = (state_reg == ACCESS) && write_reg && !err_reg;
   assign ram_wdata = wdata_reg[{cnt_reg, 3'b000} +: 8];
   assign last_byte = (cnt_reg == 3'(LANES - 1));

   byte_ram #(
      .ADDR_W (ADDR_W)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .addr  (ram_addr),
      .wdata (ram_wdata),
      .rdata (ram_rdata)
   );

   // A misaligned request spends one idle ACCESS cycle so its error
   // response appears one cycle after acceptance, never touching the RAM.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (req_valid) begin
               state_next = ACCESS;
            end
         end
         ACCESS: begin
            if (err_reg || last_byte) begin
               state_next = RESP;
            end
         end
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= IDLE;
         addr_reg  <= '0;
         write_reg <= 1'b0;
         err_reg   <= 1'b0;
         wdata_reg <= '0;
         ldata_reg <= '0;
         rdata_reg <= '0;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         case (state_reg)
            IDLE: begin
               if (req_valid) begin
                  addr_reg  <= req_addr[ADDR_W-1:0];
                  write_reg <= req_write;
                  wdata_reg <= req_wdata;
                  err_reg   <= !is_aligned(req_addr);
                  cnt_reg   <= '0;
               end
            end
            ACCESS: begin
               if (!err_reg) begin
                  cnt_reg <= cnt_reg + 3'd1;
                  if (!write_reg) begin
                     ldata_reg[{cnt_reg, 3'b000} +: 8] <= ram_rdata;
                     // Publish the load result together with the entry into RESP.
                     if (last_byte) begin
                        rdata_reg <= {ram_rdata, ldata_reg[DATA_W-9:0]};
                     end
                  end
               end
            end
            RESP: begin
               err_reg <= 1'b0;
            end
            default: begin
               err_reg <= 1'b0;
               cnt_reg <= '0;
            end
         endcase
      end
   end

   assign req_ready = (state_reg == IDLE);
   assign rsp_valid = (state_reg == RESP);
   assign rsp_err   = (state_reg == RESP) && err_reg;
   assign rsp_rdata = rdata_reg;
   assign state_out = state_reg;

endmodule
